// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus FIFO endpoint.
// Holds the destination-ID layout and the broadcast ID.
package bus_ep_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned PKT_MAX_W = 256;
  localparam int unsigned STAT_W    = 16;

  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned         pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy counter.
// A write while full is accepted only when a read frees a slot on the same edge.
module ep_sync_fifo #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(depth));
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage has no reset; the zeroed count makes its contents unobservable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_fifo_endpoint.sv
// Device-side bus endpoint: TX FIFO feeding the bus pull interface, RX FIFO behind an ID filter.
// Define ENDPOINT_STATS_EN to add saturating stat_tx/stat_rx/stat_drop counters.
module bus_fifo_endpoint
  import bus_ep_pkg::*;
#(
  parameter int unsigned pckg_sz = 32,
  parameter int unsigned depth   = 16,
  parameter logic [7:0]  MY_ID   = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic               err_pop,
  output logic               err_ovf
`ifdef ENDPOINT_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_tx,
  output logic [STAT_W-1:0]  stat_rx,
  output logic [STAT_W-1:0]  stat_drop
`endif
);

  logic            tx_empty, rx_empty, rx_full;
  logic [ID_W-1:0] push_id;
  logic            id_ok, rx_accept, rx_drop, rx_filtered, tx_pop_ok;
  logic            err_pop_q, err_pop_d, err_ovf_q, err_ovf_d;

  ep_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk  (clk),
    .rst_n(reset),
    .wr   (tx_wr),
    .din  (tx_data),
    .rd   (pop),
    .dout (D_pop),
    .full (tx_full),
    .empty(tx_empty)
  );

  ep_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk  (clk),
    .rst_n(reset),
    .wr   (rx_accept),
    .din  (D_push),
    .rd   (rx_rd),
    .dout (rx_data),
    .full (rx_full),
    .empty(rx_empty)
  );

  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;
  assign err_pop  = err_pop_q;
  assign err_ovf  = err_ovf_q;

  // A read on the same edge makes room, so a full RX FIFO only drops without rx_rd.
  assign push_id     = pkt_id(PKT_MAX_W'(D_push), pckg_sz);
  assign id_ok       = (push_id == MY_ID) || (push_id == BCAST_ID);
  assign rx_accept   = push & id_ok;
  assign rx_drop     = rx_accept & rx_full & ~rx_rd;
  assign rx_filtered = push & ~id_ok;
  assign tx_pop_ok   = pop & ~tx_empty;

  always_comb begin
    err_pop_d = err_pop_q | (pop & tx_empty);
    err_ovf_d = err_ovf_q | rx_drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pop_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_pop_q <= err_pop_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef ENDPOINT_STATS_EN
  logic [STAT_W-1:0] stat_tx_q, stat_tx_d;
  logic [STAT_W-1:0] stat_rx_q, stat_rx_d;
  logic [STAT_W-1:0] stat_drop_q, stat_drop_d;

  assign stat_tx   = stat_tx_q;
  assign stat_rx   = stat_rx_q;
  assign stat_drop = stat_drop_q;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_tx_d   = stat_tx_q;
    stat_rx_d   = stat_rx_q;
    stat_drop_d = stat_drop_q;
    if (tx_pop_ok && stat_tx_q != '1)
      stat_tx_d = stat_tx_q + STAT_W'(1);
    if (rx_accept && !rx_drop && stat_rx_q != '1)
      stat_rx_d = stat_rx_q + STAT_W'(1);
    if ((rx_drop || rx_filtered) && stat_drop_q != '1)
      stat_drop_d = stat_drop_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_tx_q   <= '0;
      stat_rx_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_tx_q   <= stat_tx_d;
      stat_rx_q   <= stat_rx_d;
      stat_drop_q <= stat_drop_d;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = tx_pop_ok ^ rx_filtered;
`endif

endmodule

// File: tb/tb_bus_fifo_endpoint.sv
// Self-checking bench for bus_fifo_endpoint (MY_ID=5, depth=16) with queue scoreboards.
// Stats counters are checked too when ENDPOINT_STATS_EN is defined.
module tb_bus_fifo_endpoint;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  ID    = 8'h05;

  logic          clk = 1'b0;
  logic          reset;
  logic          pndng;
  logic [W-1:0]  D_pop;
  logic          pop;
  logic          push;
  logic [W-1:0]  D_push;
  logic          tx_wr;
  logic [W-1:0]  tx_data;
  logic          tx_full;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          rx_rd;
  logic          err_pop;
  logic          err_ovf;
`ifdef ENDPOINT_STATS_EN
  logic [15:0]   stat_tx, stat_rx, stat_drop;
`endif

  bus_fifo_endpoint #(.pckg_sz(W), .depth(DEPTH), .MY_ID(ID)) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .push    (push),
    .D_push  (D_push),
    .tx_wr   (tx_wr),
    .tx_data (tx_data),
    .tx_full (tx_full),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_rd   (rx_rd),
    .err_pop (err_pop),
    .err_ovf (err_ovf)
`ifdef ENDPOINT_STATS_EN
    ,
    .stat_tx  (stat_tx),
    .stat_rx  (stat_rx),
    .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic         exp_err_pop, exp_err_ovf;
  logic [15:0]  exp_stat_tx, exp_stat_rx, exp_stat_drop;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    tx_q.delete();
    rx_q.delete();
    exp_err_pop   = 1'b0;
    exp_err_ovf   = 1'b0;
    exp_stat_tx   = '0;
    exp_stat_rx   = '0;
    exp_stat_drop = '0;
  endtask

  task automatic check_all(input string ctx);
    logic [W-1:0] tx_head, rx_head;
    tx_head = (tx_q.size() != 0) ? tx_q[0] : '0;
    rx_head = (rx_q.size() != 0) ? rx_q[0] : '0;
    check({ctx, ".pndng"},    W'(pndng),    W'(tx_q.size() != 0));
    check({ctx, ".D_pop"},    D_pop,        tx_head);
    check({ctx, ".tx_full"},  W'(tx_full),  W'(tx_q.size() == DEPTH));
    check({ctx, ".rx_valid"}, W'(rx_valid), W'(rx_q.size() != 0));
    check({ctx, ".rx_data"},  rx_data,      rx_head);
    check({ctx, ".err_pop"},  W'(err_pop),  W'(exp_err_pop));
    check({ctx, ".err_ovf"},  W'(err_ovf),  W'(exp_err_ovf));
`ifdef ENDPOINT_STATS_EN
    check({ctx, ".stat_tx"},   W'(stat_tx),   W'(exp_stat_tx));
    check({ctx, ".stat_rx"},   W'(stat_rx),   W'(exp_stat_rx));
    check({ctx, ".stat_drop"}, W'(stat_drop), W'(exp_stat_drop));
`endif
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One clock of stimulus; the scoreboard is updated from the pre-edge state.
  task automatic step(input string ctx, input logic t_wr, input logic [W-1:0] t_d,
                      input logic p, input logic ps, input logic [W-1:0] d_ps,
                      input logic rr);
    logic pop_ok, wr_ok, acc, rd_ok, rwr_ok;
    logic [7:0] pid;
    pop_ok = p && (tx_q.size() != 0);
    wr_ok  = t_wr && ((tx_q.size() < DEPTH) || pop_ok);
    if (p && !pop_ok) exp_err_pop = 1'b1;
    if (pop_ok) begin
      void'(tx_q.pop_front());
      exp_stat_tx = sat_inc(exp_stat_tx);
    end
    if (wr_ok) tx_q.push_back(t_d);
    pid    = d_ps[W-1 -: 8];
    acc    = ps && (pid == ID || pid == 8'hFF);
    rd_ok  = rr && (rx_q.size() != 0);
    rwr_ok = acc && ((rx_q.size() < DEPTH) || rd_ok);
    if (rd_ok) void'(rx_q.pop_front());
    if (rwr_ok) begin
      rx_q.push_back(d_ps);
      exp_stat_rx = sat_inc(exp_stat_rx);
    end
    if (acc && !rwr_ok) begin
      exp_err_ovf   = 1'b1;
      exp_stat_drop = sat_inc(exp_stat_drop);
    end
    if (ps && !acc) exp_stat_drop = sat_inc(exp_stat_drop);

    tx_wr = t_wr; tx_data = t_d; pop = p; push = ps; D_push = d_ps; rx_rd = rr;
    @(posedge clk);
    #1;
    tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    check_all(ctx);
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    step("tx_write", 1'b1, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic bus_pop();
    step("bus_pop", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic bus_push(input logic [W-1:0] d, input logic rr);
    step("bus_push", 1'b0, '0, 1'b0, 1'b1, d, rr);
  endtask

  task automatic dev_read();
    step("dev_read", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    clear_model();
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all("after_reset");
  endtask

  initial begin
    reset = 1'b0;
    tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;
    step("idle", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Reset with three TX entries queued.
    tx_write(32'h0500_0001);
    tx_write(32'h0500_0002);
    tx_write(32'h0500_0003);
    check("pndng_before_reset", W'(pndng), W'(1));
    async_reset();

    // FWFT head ordering on the bus side.
    tx_write(32'h0300_00AA);
    tx_write(32'h0300_00BB);
    check("d_pop_first", D_pop, 32'h0300_00AA);
    bus_pop();
    check("d_pop_second", D_pop, 32'h0300_00BB);
    bus_pop();
    check("pndng_fall", W'(pndng), W'(0));

    // Pop with nothing pending sets the sticky error and moves nothing.
    bus_pop();
    check("err_pop_set", W'(err_pop), W'(1));
    tx_write(32'h0300_0011);
    check("no_ptr_move", D_pop, 32'h0300_0011);

    // Fill TX, write while full, then write+pop on the same edge.
    for (int i = 1; i < DEPTH; i++) tx_write(32'h0300_1000 + W'(i));
    check("tx_full_set", W'(tx_full), W'(1));
    tx_write(32'hDEAD_BEEF);
    step("tx_wr_pop_full", 1'b1, 32'h0300_2222, 1'b1, 1'b0, '0, 1'b0);
    check("tx_full_kept", W'(tx_full), W'(1));
    for (int i = 0; i < DEPTH; i++) bus_pop();
    check("tx_drained", W'(pndng), W'(0));

    // RX ID filter: own ID, broadcast, foreign ID.
    bus_push(32'h0500_0001, 1'b0);
    bus_push(32'hFF00_0002, 1'b0);
    bus_push(32'h0700_0003, 1'b0);
    check("rx_first", rx_data, 32'h0500_0001);
    dev_read();
    check("rx_bcast", rx_data, 32'hFF00_0002);
    dev_read();
    check("rx_filtered_gone", W'(rx_valid), W'(0));

    // RX overflow, then a push against a full FIFO with a same-edge read.
    for (int i = 0; i < DEPTH; i++) bus_push(32'h0500_0100 + W'(i), 1'b0);
    check("err_ovf_clear", W'(err_ovf), W'(0));
    bus_push(32'h0500_0EEE, 1'b0);
    check("err_ovf_set", W'(err_ovf), W'(1));
    bus_push(32'h0500_0777, 1'b1);
    check("rx_head_after_rw", rx_data, 32'h0500_0101);
    for (int i = 0; i < DEPTH; i++) dev_read();
    check("rx_drained", W'(rx_valid), W'(0));
    check("err_ovf_sticky", W'(err_ovf), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
